// File: rtl/perm_pkg.sv
// perm_pkg: shared FSM encoding and lane rotation helper for the permute scheduler
package perm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int rot_sel(int lane, int r, logic dir, int n);
    return (lane + (dir ? n - r : r)) % n;
  endfunction
endpackage

// File: rtl/perm_sel_gen.sv
// perm_sel_gen: maps a rotation amount to gather selects and their inverse scatter destinations
module perm_sel_gen
  import perm_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0]   r,
  output logic [N*SELW-1:0] sel_out,
  output logic [N*SELW-1:0] sel_in
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign sel_out[i*SELW +: SELW] = SELW'(rot_sel(i, int'(r), 1'b0, N));
    assign sel_in[i*SELW +: SELW]  = SELW'(rot_sel(i, int'(r), 1'b1, N));
  end
endmodule

// File: rtl/perm_sched.sv
// perm_sched: stage/beat scheduler driving rotating gather/scatter selects
module perm_sched
  import perm_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = 2,
  parameter int STGW = 4,
  parameter int BTW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STGW-1:0]   num_stages,
  input  logic [BTW-1:0]    beats_per_stage,
  output logic [N*SELW-1:0] sel_out_bus,
  output logic [N*SELW-1:0] sel_in_bus,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic [STGW-1:0]   stage_idx,
  output logic [BTW-1:0]    beat_idx,
  output logic              busy,
  output logic              done
);
  state_t state, state_nxt;
  logic [STGW-1:0] cfg_stages, stage_nxt;
  logic [BTW-1:0] cfg_beats, beat_nxt;
  logic [SELW-1:0] r_nxt;
  logic [N*SELW-1:0] out_nxt, in_nxt;
  logic last_beat, last_stage;
  assign last_beat  = beat_idx == cfg_beats - BTW'(1);
  assign last_stage = stage_idx == cfg_stages - STGW'(1);
  assign sel_valid  = state == RUN;
  assign busy       = state == RUN;
  assign done       = state == DONE;
  // Selects are computed from the next stage so they land in the same cycle as stage_idx; reset forces identity
  assign r_nxt = rst ? '0 : SELW'(int'(stage_nxt) % N);
  perm_sel_gen #(.N(N), .SELW(SELW)) u_sel_gen (.r(r_nxt), .sel_out(out_nxt), .sel_in(in_nxt));
  // Next state and index advance; indices move only on an accepted start or a transfer
  always_comb begin
    state_nxt = state;
    stage_nxt = stage_idx;
    beat_nxt  = beat_idx;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = num_stages != '0 ? RUN : DONE;
        stage_nxt = '0;
        beat_nxt  = '0;
      end
      RUN: if (sel_ready) begin
        beat_nxt  = last_beat ? '0 : beat_idx + BTW'(1);
        stage_nxt = last_beat ? stage_idx + STGW'(1) : stage_idx;
        state_nxt = last_beat && last_stage ? DONE : RUN;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // State, indices and latched configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stage_idx  <= '0;
      beat_idx   <= '0;
      cfg_stages <= '0;
      cfg_beats  <= '0;
    end else begin
      state     <= state_nxt;
      stage_idx <= stage_nxt;
      beat_idx  <= beat_nxt;
      if (state == IDLE && start) begin
        cfg_stages <= num_stages;
        cfg_beats  <= beats_per_stage == '0 ? BTW'(1) : beats_per_stage;
      end
    end
  end
  // Registered select buses
  always_ff @(posedge clk) begin
    sel_out_bus <= out_nxt;
    sel_in_bus  <= in_nxt;
  end
endmodule

// File: tb/tb_perm_sched.sv
// tb_perm_sched: randomized and directed check of perm_sched against a beat-queue reference model
module tb_perm_sched;
  localparam int N = 4, SELW = 2, STGW = 4, BTW = 8;
  logic clk = 0, rst, start, sel_ready, sel_valid, busy, done;
  logic [STGW-1:0] num_stages, stage_idx;
  logic [BTW-1:0] beats_per_stage, beat_idx;
  logic [N*SELW-1:0] sel_out_bus, sel_in_bus;
  int checks = 0, passed = 0;
  int q[$];
  logic m_done, m_fresh;
  always #5 clk = ~clk;
  perm_sched #(.N(N), .SELW(SELW), .STGW(STGW), .BTW(BTW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_stages(num_stages),
    .beats_per_stage(beats_per_stage), .sel_out_bus(sel_out_bus), .sel_in_bus(sel_in_bus),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .stage_idx(stage_idx), .beat_idx(beat_idx),
    .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [N*SELW-1:0] gather_of(input int s);
    logic [N*SELW-1:0] v;
    for (int i = 0; i < N; i++) v[i*SELW +: SELW] = SELW'((i + s) % N);
    return v;
  endfunction
  function automatic logic [N*SELW-1:0] scatter_of(input int s);
    logic [N*SELW-1:0] v;
    for (int i = 0; i < N; i++) v[i*SELW +: SELW] = SELW'((i - (s % N) + N) % N);
    return v;
  endfunction
  task automatic check_outputs();
    chk("sel_valid", 32'(sel_valid), 32'(q.size() > 0));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("done", 32'(done), 32'(m_done));
    if (q.size() > 0) begin
      chk("stage_idx", 32'(stage_idx), 32'(q[0] / 256));
      chk("beat_idx", 32'(beat_idx), 32'(q[0] % 256));
      chk("sel_out", 32'(sel_out_bus), 32'(gather_of(q[0] / 256)));
      chk("sel_in", 32'(sel_in_bus), 32'(scatter_of(q[0] / 256)));
    end else if (m_fresh) begin
      chk("idle_stage", 32'(stage_idx), 0);
      chk("idle_beat", 32'(beat_idx), 0);
      chk("idle_sel_out", 32'(sel_out_bus), 32'(gather_of(0)));
      chk("idle_sel_in", 32'(sel_in_bus), 32'(scatter_of(0)));
    end
  endtask
  task automatic model_update(input logic r_, s_, input int ns_, bp_, input logic rd_);
    logic was_done;
    was_done = m_done;
    m_done = 0;
    if (r_) begin
      q.delete();
      m_fresh = 1;
    end else if (q.size() > 0) begin
      if (rd_) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1;
      end
    end else if (!was_done && s_) begin
      m_fresh = 0;
      if (ns_ == 0) m_done = 1;
      for (int s = 0; s < ns_; s++)
        for (int b = 0; b < (bp_ == 0 ? 1 : bp_); b++) q.push_back(s * 256 + b);
    end
  endtask
  task automatic step(input logic r_, s_, input int ns_, bp_, input logic rd_);
    check_outputs();
    rst = r_; start = s_; num_stages = STGW'(ns_); beats_per_stage = BTW'(bp_); sel_ready = rd_;
    @(posedge clk);
    model_update(r_, s_, ns_, bp_, rd_);
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] d[N], g[N], o[N];
    logic [N*SELW-1:0] so, si;
    rst = 1; start = 1; num_stages = 3; beats_per_stage = 2; sel_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_done = 0; m_fresh = 1;
    chk("reset_sel_out", 32'(sel_out_bus), 32'h000000E4);
    chk("reset_sel_in", 32'(sel_in_bus), 32'h000000E4);
    chk("reset_valid", 32'(sel_valid), 0);
    chk("reset_done", 32'(done), 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 3, 2, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("stage1_sel_out", 32'(sel_out_bus), 32'h00000039);
    chk("stage1_sel_in", 32'(sel_in_bus), 32'h00000093);
    so = sel_out_bus; si = sel_in_bus;
    d[0] = 8'hA1; d[1] = 8'hB2; d[2] = 8'hC3; d[3] = 8'hD4;
    for (int i = 0; i < N; i++) g[i] = d[so[i*SELW +: SELW]];
    for (int k = 0; k < N; k++) o[k] = g[si[k*SELW +: SELW]];
    chk("gather_scatter", {o[3], o[2], o[1], o[0]}, 32'hD4C3B2A1);
    step(0, 1, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 3, 2, 1);
    for (int i = 0; i < 20; i++) step(0, i % 5 == 2, 2, 1, (i % 4 == 0) || (i % 4 == 3));
    step(0, 1, 0, 3, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 3, 2, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 2, 2, 1);
    step(0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(49) == 0, $urandom_range(3) == 0, int'($urandom_range(4)),
           int'($urandom_range(3)), $urandom_range(2) != 0);
    check_outputs();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
